// File: rtl/rom_pattern_loader.sv
// Fills the SoC program ROM through the rom_loader handshake before the CPU is released.
// Each session streams a run-time number of words in one of four pattern modes, with a per-word timeout.
module rom_pattern_loader #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    CNT_WIDTH      = 16,
  parameter int                    SETUP_CYCLES   = 2,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS      = 16'hB400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [CNT_WIDTH-1:0]  words_to_load,
  output logic                  rom_loader_reset,
  output logic                  rom_loader_load,
  output logic [DATA_WIDTH-1:0] rom_loader_data,
  input  logic                  rom_loader_load_received,
  input  logic                  rom_loader_ack,
  output logic                  busy,
  output logic                  done_loading,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE, SETUP, PRESENT, WAIT_RECV, WAIT_ACK, DONE, ERROR
  } state_t;

  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic                    run_armed;
  logic [1:0]              mode_q;
  logic [CNT_WIDTH-1:0]    count_q;
  logic [DATA_WIDTH-1:0]   word;
  logic [31:0]             setup_cnt;
  logic [31:0]             tmo_cnt;
  logic                    start;
  logic                    tmo_hit;
  logic [CNT_WIDTH-1:0]    loaded_next;

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0] m,
                                                      input logic [DATA_WIDTH-1:0] w);
    case (m)
      2'd0:    next_word = w + 1'b1;
      2'd1:    next_word = w;
      2'd2:    next_word = {w[DATA_WIDTH-2:0], w[DATA_WIDTH-1]};
      default: next_word = w[0] ? ((w >> 1) ^ LFSR_TAPS) : (w >> 1);
    endcase
  endfunction

  // run_armed remembers that run was seen low, so a level held across reset is not an edge.
  assign start       = run && run_armed && (state == IDLE || state == DONE || state == ERROR);
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
  assign loaded_next = words_loaded + 1'b1;
  assign rom_loader_data = word;

  // NOTE: every register here is state, so all assignments are non-blocking; blocking ones
  // would make the result depend on statement order and on other always blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      run_armed        <= ~run;
      mode_q           <= 2'd0;
      count_q          <= '0;
      word             <= '0;
      setup_cnt        <= '0;
      tmo_cnt          <= '0;
      rom_loader_reset <= 1'b0;
      rom_loader_load  <= 1'b0;
      busy             <= 1'b0;
      done_loading     <= 1'b0;
      error            <= 1'b0;
      words_loaded     <= '0;
    end else begin
      run_armed <= ~run;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            error        <= 1'b0;
            words_loaded <= '0;
            mode_q       <= mode;
            count_q      <= words_to_load;
            setup_cnt    <= '0;
            word         <= (mode == 2'd3 && base == '0) ? DATA_WIDTH'(1) : base;
            if (words_to_load == '0) begin
              state        <= DONE;
              done_loading <= 1'b1;
              busy         <= 1'b0;
            end else begin
              state            <= SETUP;
              done_loading     <= 1'b0;
              busy             <= 1'b1;
              rom_loader_reset <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state           <= PRESENT;
            rom_loader_load <= 1'b1;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        PRESENT: begin
          state   <= WAIT_RECV;
          tmo_cnt <= '0;
        end
        WAIT_RECV: begin
          if (rom_loader_load_received) begin
            state           <= WAIT_ACK;
            rom_loader_load <= 1'b0;
            tmo_cnt         <= '0;
          end else if (tmo_hit) begin
            state            <= ERROR;
            error            <= 1'b1;
            busy             <= 1'b0;
            rom_loader_load  <= 1'b0;
            rom_loader_reset <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (rom_loader_ack) begin
            words_loaded <= loaded_next;
            if (loaded_next == count_q) begin
              state            <= DONE;
              done_loading     <= 1'b1;
              busy             <= 1'b0;
              rom_loader_reset <= 1'b0;
            end else begin
              word            <= next_word(mode_q, word);
              state           <= PRESENT;
              rom_loader_load <= 1'b1;
            end
          end else if (tmo_hit) begin
            state            <= ERROR;
            error            <= 1'b1;
            busy             <= 1'b0;
            rom_loader_load  <= 1'b0;
            rom_loader_reset <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_pattern_loader.sv
// Bench for rom_pattern_loader: table of pattern sessions plus directed corner-case sequences.
// A configurable responder plays the SoC side of the load/ack handshake.
module tb_rom_pattern_loader;

  logic        clk;
  logic        reset;
  logic        run;
  logic [1:0]  mode;
  logic [15:0] base;
  logic [15:0] words_to_load;
  logic        rom_loader_reset;
  logic        rom_loader_load;
  logic [15:0] rom_loader_data;
  logic        rom_loader_load_received;
  logic        rom_loader_ack;
  logic        busy;
  logic        done_loading;
  logic        error;
  logic [15:0] words_loaded;

  rom_pattern_loader #(
    .DATA_WIDTH(16), .CNT_WIDTH(16), .SETUP_CYCLES(2),
    .TIMEOUT_CYCLES(8), .LFSR_TAPS(16'hB400)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .mode(mode), .base(base),
    .words_to_load(words_to_load),
    .rom_loader_reset(rom_loader_reset), .rom_loader_load(rom_loader_load),
    .rom_loader_data(rom_loader_data),
    .rom_loader_load_received(rom_loader_load_received),
    .rom_loader_ack(rom_loader_ack),
    .busy(busy), .done_loading(done_loading), .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edge-side observations used by the negedge monitor.
  int   cyc = 0;
  logic recv_at_edge = 1'b0;
  logic reset_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    recv_at_edge  <= rom_loader_load_received;
    reset_at_edge <= reset;
  end

  // Monitor: record each presented word, hold violations, and load timing.
  logic [15:0] seen_words[$];
  int          hold_err = 0;
  int          first_load_cyc = 0;
  int          last_fall_cyc = 0;
  logic        prev_load = 1'b0;
  logic [15:0] prev_data = '0;
  always @(negedge clk) begin
    if (rom_loader_load && !prev_load) begin
      if (seen_words.size() == 0) first_load_cyc <= cyc;
      seen_words.push_back(rom_loader_data);
    end
    if (rom_loader_load && prev_load && rom_loader_data != prev_data) hold_err <= hold_err + 1;
    if (!rom_loader_load && prev_load) begin
      last_fall_cyc <= cyc;
      if (!recv_at_edge && !reset_at_edge) hold_err <= hold_err + 1;
    end
    prev_load <= rom_loader_load;
    prev_data <= rom_loader_data;
  end

  // Responder: load_received held from recv_lat cycles after load until load drops,
  // then a one-cycle ack ack_lat cycles later; word index `withhold` never gets its ack.
  logic resp_en = 1'b0;
  int   recv_lat = 0;
  int   ack_lat = 0;
  int   withhold = -1;
  initial begin
    int phase = 0;
    int rcnt = 0;
    int widx = 0;
    rom_loader_load_received = 1'b0;
    rom_loader_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        rom_loader_load_received = 1'b0;
        rom_loader_ack = 1'b0;
        phase = 0; rcnt = 0; widx = 0;
      end else begin
        if (phase == 3) begin
          rom_loader_ack = 1'b0;
          widx++; phase = 0; rcnt = 0;
        end
        case (phase)
          0: if (rom_loader_load) begin
               if (rcnt == recv_lat) begin rom_loader_load_received = 1'b1; phase = 1; end
               else rcnt++;
             end
          1: if (!rom_loader_load) begin
               rom_loader_load_received = 1'b0;
               if (widx == withhold) phase = 4;
               else if (ack_lat == 0) begin rom_loader_ack = 1'b1; phase = 3; end
               else begin rcnt = 1; phase = 2; end
             end
          2: if (rcnt == ack_lat) begin rom_loader_ack = 1'b1; phase = 3; end
             else rcnt++;
          default: ;
        endcase
      end
    end
  end

  typedef struct {
    logic [1:0]       mode;
    logic [15:0]      base;
    logic [15:0]      count;
    int               rl;
    int               al;
    logic [3:0][15:0] exp;
  } vec_t;

  task automatic run_session(input int id, input vec_t v);
    int start_cyc;
    int hold_base;
    int rr_drop;
    bit finished;
    resp_en = 1'b0;
    recv_lat = v.rl; ack_lat = v.al; withhold = -1;
    seen_words.delete();
    hold_base = hold_err;
    @(negedge clk);
    resp_en = 1'b1;
    mode = v.mode; base = v.base; words_to_load = v.count; run = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    check($sformatf("s%0d start busy", id), 32'(busy), 32'd1);
    check($sformatf("s%0d start done clear", id), 32'(done_loading), 32'd0);
    check($sformatf("s%0d start error clear", id), 32'(error), 32'd0);
    check($sformatf("s%0d start count clear", id), 32'(words_loaded), 32'd0);
    check($sformatf("s%0d start rom_reset", id), 32'(rom_loader_reset), 32'd1);
    mode = ~v.mode; base = ~v.base; words_to_load = 16'hFFFF;
    rr_drop = 0;
    finished = 1'b0;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(negedge clk);
      if (done_loading || error) finished = 1'b1;
      else if (!rom_loader_reset) rr_drop++;
    end
    check($sformatf("s%0d finished in bound", id), 32'(finished), 32'd1);
    check($sformatf("s%0d done", id), 32'(done_loading), 32'd1);
    check($sformatf("s%0d no error", id), 32'(error), 32'd0);
    check($sformatf("s%0d busy low", id), 32'(busy), 32'd0);
    check($sformatf("s%0d rom_reset falls at done", id), 32'(rom_loader_reset), 32'd0);
    check($sformatf("s%0d rom_reset held", id), 32'(rr_drop), 32'd0);
    check($sformatf("s%0d words_loaded", id), 32'(words_loaded), 32'(v.count));
    check($sformatf("s%0d word count seen", id), 32'(seen_words.size()), 32'(v.count));
    check($sformatf("s%0d setup length", id), 32'(first_load_cyc - start_cyc), 32'd2);
    check($sformatf("s%0d load hold", id), 32'(hold_err - hold_base), 32'd0);
    for (int i = 0; i < int'(v.count) && i < seen_words.size(); i++)
      check($sformatf("s%0d word%0d", id, i), 32'(seen_words[i]), 32'(v.exp[i]));
    run = 1'b0;
    repeat (3) @(negedge clk);
    check($sformatf("s%0d done stable", id), 32'(done_loading), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{mode: 2'd0, base: 16'h0100, count: 16'd4, rl: 1, al: 2,
                exp: {16'h0103, 16'h0102, 16'h0101, 16'h0100}};
    vecs[1] = '{mode: 2'd2, base: 16'h8001, count: 16'd3, rl: 0, al: 0,
                exp: {16'h0000, 16'h0006, 16'h0003, 16'h8001}};
    vecs[2] = '{mode: 2'd3, base: 16'h0000, count: 16'd2, rl: 0, al: 1,
                exp: {16'h0000, 16'h0000, 16'hB400, 16'h0001}};
    vecs[3] = '{mode: 2'd1, base: 16'hA5A5, count: 16'd3, rl: 2, al: 0,
                exp: {16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5}};
    vecs[4] = '{mode: 2'd3, base: 16'hB400, count: 16'd3, rl: 0, al: 0,
                exp: {16'h0000, 16'h2D00, 16'h5A00, 16'hB400}};
    vecs[5] = '{mode: 2'd0, base: 16'hFFFE, count: 16'd3, rl: 1, al: 1,
                exp: {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE}};

    // Reset with run held high: outputs clear and no session starts afterwards.
    reset = 1'b1; run = 1'b1; mode = 2'd0; base = 16'h1234; words_to_load = 16'd2;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rom_reset", 32'(rom_loader_reset), 32'd0);
    check("reset load", 32'(rom_loader_load), 32'd0);
    check("reset data", 32'(rom_loader_data), 32'd0);
    check("reset done", 32'(done_loading), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset words_loaded", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("run across reset no start", 32'(busy), 32'd0);
    check("run across reset no rom_reset", 32'(rom_loader_reset), 32'd0);
    run = 1'b0;

    for (int v = 0; v < 6; v++) run_session(v, vecs[v]);

    // Zero-length session: done one cycle after the edge, no handshake at all.
    seen_words.delete();
    @(negedge clk);
    mode = 2'd0; base = 16'h0042; words_to_load = 16'd0; run = 1'b1;
    @(negedge clk);
    check("zero done", 32'(done_loading), 32'd1);
    check("zero busy", 32'(busy), 32'd0);
    check("zero rom_reset", 32'(rom_loader_reset), 32'd0);
    repeat (3) @(negedge clk);
    check("zero no load", 32'(seen_words.size()), 32'd0);
    run = 1'b0;

    // Timeout: second word never acknowledged.
    begin
      bit hit;
      resp_en = 1'b0; recv_lat = 0; ack_lat = 0; withhold = 1;
      @(negedge clk);
      resp_en = 1'b1; mode = 2'd0; base = 16'h0000; words_to_load = 16'd4; run = 1'b1;
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(negedge clk);
        if (error) hit = 1'b1;
      end
      check("tmo error raised", 32'(hit), 32'd1);
      check("tmo latency", 32'(cyc - last_fall_cyc), 32'd8);
      check("tmo words_loaded", 32'(words_loaded), 32'd1);
      check("tmo load low", 32'(rom_loader_load), 32'd0);
      check("tmo rom_reset low", 32'(rom_loader_reset), 32'd0);
      check("tmo busy low", 32'(busy), 32'd0);
      check("tmo done low", 32'(done_loading), 32'd0);
      run = 1'b0;
      repeat (3) @(negedge clk);
      check("tmo error sticky", 32'(error), 32'd1);
    end

    // Reset during WAIT_RECV of word 5, then a fresh session restarts from word 0.
    begin
      bit got5;
      resp_en = 1'b0; recv_lat = 3; ack_lat = 0; withhold = -1;
      seen_words.delete();
      @(negedge clk);
      resp_en = 1'b1; mode = 2'd0; base = 16'h0010; words_to_load = 16'd8; run = 1'b1;
      @(negedge clk);
      check("rst start clears error", 32'(error), 32'd0);
      got5 = 1'b0;
      for (int k = 0; k < 200 && !got5; k++) begin
        @(negedge clk);
        if (seen_words.size() == 5) got5 = 1'b1;
      end
      check("rst reached word5", 32'(got5), 32'd1);
      @(negedge clk);
      check("rst pre count", 32'(words_loaded), 32'd4);
      reset = 1'b1; resp_en = 1'b0;
      @(negedge clk);
      check("rst load", 32'(rom_loader_load), 32'd0);
      check("rst rom_reset", 32'(rom_loader_reset), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst words_loaded", 32'(words_loaded), 32'd0);
      check("rst data", 32'(rom_loader_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("rst run high no restart", 32'(busy), 32'd0);
      check("rst no new load", 32'(seen_words.size()), 32'd5);
      run = 1'b0;
      run_session(6, '{mode: 2'd0, base: 16'h0010, count: 16'd2, rl: 0, al: 0,
                       exp: {16'h0000, 16'h0000, 16'h0011, 16'h0010}});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
